pc_command_sequencer: RTL and testbench

- Parametrised successor to the board's button/switch-to-PC command front end.
- Holds N selectable modes, each with a wrapping value counter.
- Builds a command byte {opcode, payload} and queues it in a small FIFO.
- Drains the FIFO to the UART transmitter over a valid/ready handshake, with auto-repeat while the send button is held and BCD outputs for the 2-digit seven-segment controller.

---
 rtl/pc_command_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pc_command_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_command_sequencer: mode/counter command builder feeding a FWFT queue  |
// | that drains to the UART transmitter. Rev 1.0                             |
// +--------------------------------------------------------------------------+
module pc_command_sequencer #(
    parameter int NUM_MODES = 8,
    parameter logic [NUM_MODES*5-1:0] MODE_MAX =
        {5'd8, 5'd0, 5'd25, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0},
    parameter logic [NUM_MODES*3-1:0] MODE_OP =
        {3'b100, 3'b100, 3'b101, 3'b110, 3'b011, 3'b000, 3'b010, 3'b001},
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          next_btn,
    input  logic          prev_btn,
    input  logic          inc_btn,
    input  logic          send_btn,
    input  logic          dir,
    input  logic          invert,
    input  logic [4:0]    sw,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [MW-1:0] mode,
    output logic [3:0]    disp_tens,
    output logic [3:0]    disp_ones,
    output logic          overflow
);

    localparam logic [MW-1:0] C_LAST_MODE = MW'(NUM_MODES - 1);
    localparam int C_TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_TW = $clog2(C_TMAX + 1);
    localparam logic [C_TW-1:0] C_DELAY  = C_TW'(REPEAT_DELAY);
    localparam logic [C_TW-1:0] C_PERIOD = C_TW'(REPEAT_PERIOD);
    localparam int C_AW = $clog2(FIFO_DEPTH);
    localparam logic [C_AW:0] C_DEPTH = (C_AW + 1)'(FIFO_DEPTH);

    logic r_next_q, r_prev_q, r_inc_q, r_send_q;
    logic w_rise_next, w_rise_prev, w_rise_inc, w_rise_send;

    logic [MW-1:0] r_mode;
    logic [4:0]    r_cnt;
    logic [4:0]    w_max;
    logic [2:0]    w_op;
    logic [4:0]    w_payload;
    logic [7:0]    w_byte;

    logic [C_TW-1:0] r_tmr;
    logic            r_first;
    logic            w_rep_hit;
    logic            w_push;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [C_AW-1:0] r_rd, r_wr, w_rd_next;
    logic [C_AW:0] r_count, w_count_pop, w_count_next;
    logic          w_pop, w_push_ok;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_overflow;

    logic [4:0]    w_rem;
    logic [3:0]    w_tens;

    assign w_rise_next = next_btn & ~r_next_q;
    assign w_rise_prev = prev_btn & ~r_prev_q;
    assign w_rise_inc  = inc_btn  & ~r_inc_q;
    assign w_rise_send = send_btn & ~r_send_q;

    // History resets high so a button held through reset yields no rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_q <= 1'b1;
            r_prev_q <= 1'b1;
            r_inc_q  <= 1'b1;
            r_send_q <= 1'b1;
        end else begin
            r_next_q <= next_btn;
            r_prev_q <= prev_btn;
            r_inc_q  <= inc_btn;
            r_send_q <= send_btn;
        end
    end

    assign w_max     = MODE_MAX[int'(r_mode)*5 +: 5];
    assign w_op      = MODE_OP[int'(r_mode)*3 +: 3];
    assign w_payload = (w_max == 5'd0) ? (invert ? ~sw : sw) : r_cnt;
    assign w_byte    = {w_op, w_payload};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= '0;
            r_cnt  <= 5'd0;
        end else if (w_rise_inc) begin
            if (dir) begin
                r_cnt <= (r_cnt == w_max) ? 5'd0 : r_cnt + 5'd1;
            end else begin
                r_cnt <= (r_cnt == 5'd0) ? w_max : r_cnt - 5'd1;
            end
        end else if (w_rise_next) begin
            r_mode <= (r_mode == C_LAST_MODE) ? '0 : r_mode + MW'(1);
            r_cnt  <= 5'd0;
        end else if (w_rise_prev) begin
            r_mode <= (r_mode == '0) ? C_LAST_MODE : r_mode - MW'(1);
            r_cnt  <= 5'd0;
        end
    end

    // r_tmr counts cycles since the rise (or last repeat); zero means not armed.
    assign w_rep_hit = send_btn & (r_tmr != '0) & (r_tmr == (r_first ? C_DELAY : C_PERIOD));
    assign w_push    = w_rise_send | w_rep_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr   <= '0;
            r_first <= 1'b0;
        end else if (!send_btn) begin
            r_tmr   <= '0;
        end else if (w_rise_send) begin
            r_tmr   <= C_TW'(1);
            r_first <= 1'b1;
        end else if (r_tmr != '0) begin
            if (w_rep_hit) begin
                r_tmr   <= C_TW'(1);
                r_first <= 1'b0;
            end else begin
                r_tmr <= r_tmr + C_TW'(1);
            end
        end
    end

    assign w_pop        = r_tx_valid & tx_ready;
    assign w_count_pop  = r_count - (C_AW + 1)'(w_pop);
    assign w_push_ok    = w_push & (w_count_pop < C_DEPTH);
    assign w_count_next = w_count_pop + (C_AW + 1)'(w_push_ok);
    assign w_rd_next    = r_rd + C_AW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= w_byte;
        end
    end

    // Head register holds the next-state head so tx_data is valid with tx_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            r_rd       <= w_rd_next;
            r_wr       <= r_wr + C_AW'(w_push_ok);
            r_count    <= w_count_next;
            r_tx_valid <= (w_count_next != '0);
            if (w_count_pop == '0) begin
                if (w_push_ok) begin
                    r_tx_data <= w_byte;
                end
            end else begin
                r_tx_data <= r_mem[w_rd_next];
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tens = 4'd0;
        w_rem  = r_cnt;
        if (r_cnt >= 5'd30) begin
            w_tens = 4'd3;
            w_rem  = r_cnt - 5'd30;
        end else if (r_cnt >= 5'd20) begin
            w_tens = 4'd2;
            w_rem  = r_cnt - 5'd20;
        end else if (r_cnt >= 5'd10) begin
            w_tens = 4'd1;
            w_rem  = r_cnt - 5'd10;
        end
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign mode      = r_mode;
    assign disp_tens = w_tens;
    assign disp_ones = w_rem[3:0];
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_command_sequencer.sv
`default_nettype none
// Bench for pc_command_sequencer: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_pc_command_sequencer;

    localparam int D = 10;
    localparam int P = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, next_btn, prev_btn, inc_btn, send_btn, dir, invert, tx_ready;
    logic [4:0] sw;
    logic [7:0] tx_data;
    logic       tx_valid, overflow;
    logic [2:0] mode;
    logic [3:0] disp_tens, disp_ones;

    pc_command_sequencer #(
        .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .clk(clk), .reset(reset), .next_btn(next_btn), .prev_btn(prev_btn),
        .inc_btn(inc_btn), .send_btn(send_btn), .dir(dir), .invert(invert),
        .sw(sw), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mode(mode), .disp_tens(disp_tens), .disp_ones(disp_ones), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int mmax [8] = '{0, 0, 0, 0, 9, 25, 0, 8};
    int mop  [8] = '{1, 2, 0, 3, 6, 5, 4, 4};
    int m_mode, m_cnt, m_hold;
    bit m_ovf;
    bit h_next, h_prev, h_inc, h_send;
    logic [7:0] m_q [$];

    function automatic logic [7:0] model_byte();
        logic [4:0] s;
        int pl;
        s  = invert ? ~sw : sw;
        pl = (mmax[m_mode] == 0) ? int'(s) : m_cnt;
        return 8'((mop[m_mode] << 5) | pl);
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        logic [7:0] b;
        bit push;
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_hold = -1; m_ovf = 0;
            m_q.delete();
            h_next = 1; h_prev = 1; h_inc = 1; h_send = 1;
        end else begin
            b    = model_byte();
            push = 0;
            if (send_btn && !h_send) begin
                push = 1; m_hold = 0;
            end else if (send_btn && m_hold >= 0) begin
                m_hold++;
                if (m_hold >= D && (m_hold - D) % P == 0) push = 1;
            end else if (!send_btn) begin
                m_hold = -1;
            end
            if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(b);
                else m_ovf = 1;
            end
            if (inc_btn && !h_inc) begin
                if (dir) m_cnt = (m_cnt + 1) % (mmax[m_mode] + 1);
                else     m_cnt = (m_cnt + mmax[m_mode]) % (mmax[m_mode] + 1);
            end else if (next_btn && !h_next) begin
                m_mode = (m_mode + 1) % 8; m_cnt = 0;
            end else if (prev_btn && !h_prev) begin
                m_mode = (m_mode + 7) % 8; m_cnt = 0;
            end
            h_next = next_btn; h_prev = prev_btn; h_inc = inc_btn; h_send = send_btn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit n, input bit p, input bit i, input bit s);
        next_btn = n; prev_btn = p; inc_btn = i; send_btn = s;
        tick();
        next_btn = 0; prev_btn = 0; inc_btn = 0; send_btn = 0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        tests++;
        if (mode !== 3'd0 || tx_valid !== 1'b0 || tx_data !== 8'd0 || overflow !== 1'b0 ||
            disp_tens !== 4'd0 || disp_ones !== 4'd0) begin
            fails++;
            $display("FAIL reset: mode=%0d valid=%b data=%h ovf=%b disp=%0d%0d required all zero",
                     mode, tx_valid, tx_data, overflow, disp_tens, disp_ones);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_counter();
        repeat (4) pulse(1, 0, 0, 0);
        tests++;
        if (mode !== 3'd4) begin
            fails++; $display("FAIL next_x4: mode=%0d required 4", mode);
        end
        dir = 1;
        for (int i = 1; i <= 11; i++) begin
            pulse(0, 0, 1, 0);
            tests++;
            if (disp_tens !== 4'd0 || disp_ones !== 4'(i % 10) || m_cnt != i % 10) begin
                fails++;
                $display("FAIL inc_up %0d: disp=%0d%0d required 0%0d", i, disp_tens, disp_ones, i % 10);
            end
        end
    endtask

    task automatic test_wraps();
        repeat (4) pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        tests++;
        if (mode !== 3'd7) begin
            fails++; $display("FAIL prev_wrap: mode=%0d required 7", mode);
        end
        dir = 0;
        pulse(0, 0, 1, 0);
        tests++;
        if (disp_tens !== 4'd0 || disp_ones !== 4'd8) begin
            fails++; $display("FAIL dec_wrap: disp=%0d%0d required 08", disp_tens, disp_ones);
        end
        pulse(1, 0, 0, 0);
        tests++;
        if (mode !== 3'd0) begin
            fails++; $display("FAIL next_wrap: mode=%0d required 0", mode);
        end
        pulse(1, 1, 0, 0);
        tests++;
        if (mode !== 3'd1 || m_mode != 1) begin
            fails++; $display("FAIL next_prev: mode=%0d required 1", mode);
        end
    endtask

    task automatic test_send_basic();
        pulse(0, 1, 0, 0);
        sw = 5'b00101; invert = 1; tx_ready = 0;
        send_btn = 1;
        tick();
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'b001_11010) begin
            fails++; $display("FAIL send_basic: valid=%b data=%h required 1 3a", tx_valid, tx_data);
        end
        tx_ready = 1;
        tick();
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL send_pop: valid=%b required 0", tx_valid);
        end
        tx_ready = 0; send_btn = 0;
        tick();
    endtask

    task automatic test_repeat();
        logic [7:0] e;
        tx_ready = 0; invert = 0;
        send_btn = 1;
        for (int t = 0; t <= 22; t++) begin
            sw = 5'($urandom);
            tick();
            tests++;
            if (tx_valid !== (m_q.size() != 0) || overflow !== m_ovf ||
                (m_q.size() != 0 && tx_data !== m_q[0])) begin
                fails++;
                $display("FAIL repeat t=%0d: valid=%b data=%h ovf=%b required %b %h %b",
                         t, tx_valid, tx_data, overflow, m_q.size() != 0,
                         (m_q.size() != 0) ? m_q[0] : 8'h00, m_ovf);
            end
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++; $display("FAIL repeat_overflow: ovf=%b required 1", overflow);
        end
        send_btn = 0; tx_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            e = (m_q.size() != 0) ? m_q[0] : 8'hxx;
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                fails++; $display("FAIL repeat_drain %0d: valid=%b data=%h required 1 %h", k, tx_valid, tx_data, e);
            end
            tick();
        end
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL repeat_empty: valid=%b required 0", tx_valid);
        end
        tx_ready = 0;
    endtask

    task automatic test_full_pop();
        logic [7:0] e;
        reset = 1; tick(); reset = 0; tick();
        tx_ready = 0;
        for (int k = 0; k < DEPTH; k++) begin
            sw = 5'($urandom);
            pulse(0, 0, 0, 1);
        end
        sw = 5'($urandom);
        send_btn = 1; tx_ready = 1;
        tick();
        send_btn = 0; tx_ready = 0;
        tick();
        tests++;
        if (overflow !== 1'b0) begin
            fails++; $display("FAIL full_pop_ovf: ovf=%b required 0", overflow);
        end
        tx_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            e = (m_q.size() != 0) ? m_q[0] : 8'hxx;
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin
                fails++; $display("FAIL full_pop_drain %0d: valid=%b data=%h required 1 %h", k, tx_valid, tx_data, e);
            end
            tick();
        end
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL full_pop_count: valid=%b required 0 after four pops", tx_valid);
        end
        tx_ready = 0;
    endtask

    task automatic test_reset_held();
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        send_btn = 1; reset = 1;
        tick(); tick();
        reset = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            tests++;
            if (tx_valid !== 1'b0 || mode !== 3'd0 || overflow !== 1'b0) begin
                fails++;
                $display("FAIL reset_held t=%0d: valid=%b mode=%0d ovf=%b required 0 0 0", t, tx_valid, mode, overflow);
            end
        end
        send_btn = 0; tick();
        send_btn = 1; tick();
        tests++;
        if (tx_valid !== 1'b1) begin
            fails++; $display("FAIL reset_held_press: valid=%b required 1", tx_valid);
        end
        send_btn = 0; tx_ready = 1; tick();
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++; $display("FAIL reset_held_once: valid=%b required 0", tx_valid);
        end
        tx_ready = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) next_btn = ~next_btn;
            if ($urandom_range(0, 5) == 0) prev_btn = ~prev_btn;
            if ($urandom_range(0, 2) == 0) inc_btn  = ~inc_btn;
            if ($urandom_range(0, 7) == 0) send_btn = ~send_btn;
            dir      = 1'($urandom);
            invert   = 1'($urandom);
            sw       = 5'($urandom);
            tx_ready = ($urandom_range(0, 2) == 0);
            tick();
            tests++;
            if (mode !== 3'(m_mode) || disp_tens !== 4'(m_cnt / 10) || disp_ones !== 4'(m_cnt % 10) ||
                tx_valid !== (m_q.size() != 0) || overflow !== m_ovf ||
                (m_q.size() != 0 && tx_data !== m_q[0])) begin
                fails++;
                $display("FAIL random c=%0d: mode=%0d disp=%0d%0d valid=%b data=%h ovf=%b required %0d %0d%0d %b %h %b",
                         c, mode, disp_tens, disp_ones, tx_valid, tx_data, overflow,
                         m_mode, m_cnt / 10, m_cnt % 10, m_q.size() != 0,
                         (m_q.size() != 0) ? m_q[0] : 8'h00, m_ovf);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; next_btn = 0; prev_btn = 0; inc_btn = 0; send_btn = 0;
        dir = 1; invert = 0; sw = 5'd0; tx_ready = 0;
        test_reset();
        test_counter();
        test_wraps();
        test_send_basic();
        test_repeat();
        test_full_pop();
        test_reset_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
